// File: rtl/peak_detect_if.sv
// Stream bundle for peak_detect: polar FFT bins in, one peak/phase-difference result out.
interface peak_detect_if #(
  parameter int FFT   = 11,
  parameter int WIDTH = 25
);
  logic             sink_valid;
  logic             sink_sop;
  logic             sink_eop;
  logic [WIDTH-1:0] sink_mag;
  logic [15:0]      sink_phase;
  logic             source_valid;
  logic [FFT-1:0]   source_bin;
  logic [23:0]      source_freq;
  logic [WIDTH-1:0] source_mag;
  logic [15:0]      source_phaseA;
  logic [15:0]      source_phaseB;
  logic             source_error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
    input  source_valid, source_bin, source_freq, source_mag,
           source_phaseA, source_phaseB, source_error
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
    output source_valid, source_bin, source_freq, source_mag,
           source_phaseA, source_phaseB, source_error
  );
endinterface

// File: rtl/peak_detect.sv
// Peak-bin search on antenna 0 with phase capture on antennas 1..NSINK-1 at that bin.
// Optional macro PEAK_THRESHOLD_EN discards runs whose peak is below MIN_MAG.
module peak_detect #(
  parameter int          NSINK   = 3,
  parameter int          FFT     = 11,
  parameter int          WIDTH   = 25,
  parameter int unsigned FS      = 20000000,
  parameter int unsigned MIN_MAG = 1024
) (
  input  logic          clk,
  input  logic          reset,
  peak_detect_if.slave  bus
);

  localparam logic [FFT-1:0]     LAST_BIN  = {FFT{1'b1}};
  localparam logic [FFT-1:0]     HALF_BIN  = FFT'(2 ** (FFT - 1));
  localparam logic [1:0]         LAST_CHAN = 2'(NSINK - 1);
  localparam int                 PW        = FFT + 32;
  localparam logic signed [16:0] PI_Q      = 17'sd25736;
  localparam logic signed [16:0] TWO_PI_Q  = 17'sd51472;

`ifdef PEAK_THRESHOLD_EN
  localparam bit THRESHOLD_EN = 1'b1;
`else
  localparam bit THRESHOLD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEARCH, CAPTURE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [FFT-1:0]   bin_q, bin_d;
  logic [1:0]       chan_q, chan_d;
  logic [1:0]       skip_q, skip_d;
  logic [WIDTH-1:0] peakMag_q, peakMag_d;
  logic [FFT-1:0]   peakBin_q, peakBin_d;
  logic [15:0]      ph0_q, ph0_d;
  logic [15:0]      ph1_q, ph1_d;
  logic [15:0]      ph2_q, ph2_d;

  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [FFT-1:0]   outBin_q, outBin_d;
  logic [23:0]      freq_q, freq_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [15:0]      phA_q, phA_d;
  logic [15:0]      phB_q, phB_d;

  logic             doSearch;
  logic [FFT-1:0]   curBin;

  // Difference of two Q3.13 phases folded back into [-pi, pi].
  function automatic logic [15:0] wrapDiff(input logic [15:0] a, input logic [15:0] b);
    logic signed [16:0] d;
    d = $signed({a[15], a}) - $signed({b[15], b});
    if (d > PI_Q)       d = d - TWO_PI_Q;
    else if (d < -PI_Q) d = d + TWO_PI_Q;
    return 16'(d);
  endfunction

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    chan_d    = chan_q;
    skip_d    = skip_q;
    peakMag_d = peakMag_q;
    peakBin_d = peakBin_q;
    ph0_d     = ph0_q;
    ph1_d     = ph1_q;
    ph2_d     = ph2_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    outBin_d  = outBin_q;
    freq_d    = freq_q;
    mag_d     = mag_q;
    phA_d     = phA_q;
    phB_d     = phB_q;
    doSearch  = 1'b0;
    curBin    = bus.sink_sop ? '0 : bin_q;

    unique case (state_q)
      IDLE: begin
        if (bus.sink_valid) begin
          if (skip_q != 2'd0) begin
            if (bus.sink_eop) skip_d = skip_q - 2'd1;
          end else if (bus.sink_sop) begin
            doSearch = 1'b1;
          end
        end
      end

      SEARCH: begin
        if (bus.sink_valid) begin
          if (bus.sink_sop) err_d = 1'b1;
          doSearch = 1'b1;
        end
      end

      CAPTURE: begin
        if (bus.sink_valid) begin
          if (bus.sink_sop && (bin_q != '0)) begin
            err_d    = 1'b1;
            doSearch = 1'b1;
          end else if (!bus.sink_sop && (bin_q == '0)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            if (curBin == peakBin_q) begin
              if (chan_q == 2'd1) ph1_d = bus.sink_phase;
              else                ph2_d = bus.sink_phase;
            end
            if (bus.sink_eop || (curBin == LAST_BIN)) begin
              bin_d = '0;
              if (bus.sink_eop && (curBin == LAST_BIN)) begin
                if (chan_q == LAST_CHAN) state_d = EMIT;
                else                     chan_d  = chan_q + 2'd1;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end else begin
              bin_d = curBin + FFT'(1);
            end
          end
        end
      end

      EMIT: begin
        valid_d  = 1'b1;
        outBin_d = peakBin_q;
        mag_d    = peakMag_q;
        freq_d   = 24'((PW'(peakBin_q) * PW'(FS)) >> FFT);
        phA_d    = wrapDiff(ph1_q, ph0_q);
        phB_d    = (NSINK > 2) ? wrapDiff(ph2_q, ph0_q) : 16'd0;
        state_d  = IDLE;
        chan_d   = 2'd0;
        // A new run may begin right behind the last eop; do not drop its sop.
        if (bus.sink_valid && bus.sink_sop) doSearch = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    if (doSearch) begin
      state_d = SEARCH;
      if (bus.sink_sop) begin
        peakMag_d = '0;
        peakBin_d = '0;
        ph0_d     = bus.sink_phase;
        chan_d    = 2'd0;
      end else if ((curBin != '0) && (curBin < HALF_BIN) && (bus.sink_mag > peakMag_q)) begin
        peakMag_d = bus.sink_mag;
        peakBin_d = curBin;
        ph0_d     = bus.sink_phase;
      end
      if (bus.sink_eop || (curBin == LAST_BIN)) begin
        bin_d = '0;
        if (bus.sink_eop && (curBin == LAST_BIN)) begin
          chan_d = 2'd1;
          // Weak peak: silently drop the run and let the capture frames pass.
          if (THRESHOLD_EN && (peakMag_d < WIDTH'(MIN_MAG))) begin
            state_d = IDLE;
            skip_d  = 2'(NSINK - 1);
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end else begin
        bin_d = curBin + FFT'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      chan_q    <= '0;
      skip_q    <= '0;
      peakMag_q <= '0;
      peakBin_q <= '0;
      ph0_q     <= '0;
      ph1_q     <= '0;
      ph2_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      outBin_q  <= '0;
      freq_q    <= '0;
      mag_q     <= '0;
      phA_q     <= '0;
      phB_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      chan_q    <= chan_d;
      skip_q    <= skip_d;
      peakMag_q <= peakMag_d;
      peakBin_q <= peakBin_d;
      ph0_q     <= ph0_d;
      ph1_q     <= ph1_d;
      ph2_q     <= ph2_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      outBin_q  <= outBin_d;
      freq_q    <= freq_d;
      mag_q     <= mag_d;
      phA_q     <= phA_d;
      phB_q     <= phB_d;
    end
  end

  assign bus.source_valid  = valid_q;
  assign bus.source_error  = err_q;
  assign bus.source_bin    = outBin_q;
  assign bus.source_freq   = freq_q;
  assign bus.source_mag    = mag_q;
  assign bus.source_phaseA = phA_q;
  assign bus.source_phaseB = phB_q;

endmodule

// File: tb/tb_peak_detect.sv
// Directed bench for peak_detect (NSINK=3, FFT=11): tone, wrap, ties, gaps, framing errors, reset.
module tb_peak_detect;

  localparam int NSINK = 3;
  localparam int FFT   = 11;
  localparam int WIDTH = 25;
  localparam int NBINS = 2 ** FFT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  peak_detect_if #(.FFT(FFT), .WIDTH(WIDTH)) bus ();

  peak_detect #(
    .NSINK(NSINK), .FFT(FFT), .WIDTH(WIDTH), .FS(20000000), .MIN_MAG(1024)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int validCnt = 0;
  int errCnt = 0;
  int lastValidCycle = 0;
  int eopCycle = 0;

  int peakBins[4];
  int peakMags[4];
  int nPeaks;
  int baseMag;
  int phBin;
  logic [15:0] phAt[3];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (bus.source_valid === 1'b1) begin
      validCnt++;
      lastValidCycle = cycle;
    end
    if (bus.source_error === 1'b1) errCnt++;
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int frameMag(input int ant, input int b);
    int m;
    m = baseMag;
    if (ant == 0)
      for (int i = 0; i < nPeaks; i++)
        if (peakBins[i] == b) m = peakMags[i];
    return m;
  endfunction

  task automatic applyStimulus(input int ant, input int nBins, input bit withSop,
                               input bit withEop, input int gapPct);
    for (int b = 0; b < nBins; b++) begin
      if ($urandom_range(99) < gapPct) begin
        bus.sink_valid = 1'b0;
        repeat ($urandom_range(3, 1)) begin
          @(posedge clk);
          #1;
        end
      end
      bus.sink_valid = 1'b1;
      bus.sink_sop   = withSop && (b == 0);
      bus.sink_eop   = withEop && (b == nBins - 1);
      bus.sink_mag   = WIDTH'(frameMag(ant, b));
      bus.sink_phase = (b == phBin) ? phAt[ant] : 16'(b * 13 + ant * 1000);
      if (bus.sink_eop) eopCycle = cycle;
      @(posedge clk);
      #1;
    end
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
  endtask

  task automatic sendRun(input int gapPct);
    for (int a = 0; a < NSINK; a++) applyStimulus(a, NBINS, 1'b1, 1'b1, gapPct);
  endtask

  task automatic setTone(input int p0, input int p1, input int p2, input int mag);
    nPeaks      = 1;
    peakBins[0] = 100;
    peakMags[0] = mag;
    baseMag     = 10;
    phBin       = 100;
    phAt[0]     = 16'(p0);
    phAt[1]     = 16'(p1);
    phAt[2]     = 16'(p2);
  endtask

  task automatic expectResult(input string tag, input int vBefore, input int eBefore,
                              input int expErr, input int expBin, input int expMag,
                              input int expFreq, input int expA, input int expB);
    repeat (4) @(negedge clk);
    checkOutput({tag, ".count"}, validCnt - vBefore, 1);
    checkOutput({tag, ".latency"}, lastValidCycle - eopCycle, 2);
    checkOutput({tag, ".errors"}, errCnt - eBefore, expErr);
    checkOutput({tag, ".bin"}, bus.source_bin, expBin);
    checkOutput({tag, ".mag"}, bus.source_mag, expMag);
    checkOutput({tag, ".freq"}, bus.source_freq, expFreq);
    checkOutput({tag, ".phaseA"}, $signed(bus.source_phaseA), expA);
    checkOutput({tag, ".phaseB"}, $signed(bus.source_phaseB), expB);
  endtask

  initial begin
    int v;
    int e;
    reset          = 1'b1;
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
    bus.sink_mag   = '0;
    bus.sink_phase = '0;
    setTone(1000, 3000, -2000, 5000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.valid", bus.source_valid, 0);
    checkOutput("reset.error", bus.source_error, 0);
    checkOutput("reset.bin", bus.source_bin, 0);
    checkOutput("reset.freq", bus.source_freq, 0);
    checkOutput("reset.mag", bus.source_mag, 0);
    checkOutput("reset.phaseA", bus.source_phaseA, 0);
    checkOutput("reset.phaseB", bus.source_phaseB, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single tone");
    v = validCnt; e = errCnt;
    sendRun(0);
    expectResult("tone", v, e, 0, 100, 5000, 976562, 2000, -3000);

    $display("[TB] ties, DC and mirror");
    nPeaks = 4;
    peakBins[0] = 0;    peakMags[0] = 9000;
    peakBins[1] = 1500; peakMags[1] = 9000;
    peakBins[2] = 40;   peakMags[2] = 7000;
    peakBins[3] = 60;   peakMags[3] = 7000;
    phBin = 40;
    phAt[0] = 16'(100); phAt[1] = 16'(200); phAt[2] = 16'(300);
    v = validCnt; e = errCnt;
    sendRun(0);
    expectResult("ties", v, e, 0, 40, 7000, 390625, 100, 200);

    $display("[TB] tone with valid gaps");
    setTone(1000, 3000, -2000, 5000);
    v = validCnt; e = errCnt;
    sendRun(30);
    expectResult("gaps", v, e, 0, 100, 5000, 976562, 2000, -3000);

    $display("[TB] sop injected mid antenna-1 frame");
    v = validCnt; e = errCnt;
    applyStimulus(0, NBINS, 1'b1, 1'b1, 0);
    applyStimulus(1, 500, 1'b1, 1'b0, 0);
    sendRun(0);
    expectResult("sopinj", v, e, 1, 100, 5000, 976562, 2000, -3000);

    $display("[TB] short frame");
    v = validCnt; e = errCnt;
    applyStimulus(0, 2001, 1'b1, 1'b1, 0);
    repeat (4) @(negedge clk);
    checkOutput("short.errors", errCnt - e, 1);
    checkOutput("short.count", validCnt - v, 0);

    $display("[TB] reset during antenna-1 frame, then phase wrap run");
    setTone(20000, -20000, 24000, 5000);
    v = validCnt; e = errCnt;
    applyStimulus(0, NBINS, 1'b1, 1'b1, 0);
    applyStimulus(1, 1000, 1'b1, 1'b0, 0);
    reset = 1'b1;
    #2;
    checkOutput("midreset.bin", bus.source_bin, 0);
    checkOutput("midreset.mag", bus.source_mag, 0);
    checkOutput("midreset.freq", bus.source_freq, 0);
    checkOutput("midreset.phaseA", bus.source_phaseA, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midreset.count", validCnt - v, 0);
    sendRun(0);
    expectResult("wrap", v, e, 0, 100, 5000, 976562, 11472, 4000);

`ifdef PEAK_THRESHOLD_EN
    $display("[TB] peak below threshold");
    setTone(1000, 3000, -2000, 800);
    v = validCnt; e = errCnt;
    sendRun(0);
    repeat (6) @(negedge clk);
    checkOutput("weak.count", validCnt - v, 0);
    checkOutput("weak.errors", errCnt - e, 0);
    setTone(1000, 3000, -2000, 5000);
    v = validCnt; e = errCnt;
    sendRun(0);
    expectResult("strong", v, e, 0, 100, 5000, 976562, 2000, -3000);
`else
    $display("[TB] all-zero magnitudes");
    nPeaks  = 0;
    baseMag = 0;
    phBin   = 0;
    phAt[0] = 16'(500); phAt[1] = 16'(700); phAt[2] = 16'(-100);
    v = validCnt; e = errCnt;
    sendRun(0);
    expectResult("zero", v, e, 0, 0, 0, 0, 200, -600);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
